// File: rtl/riscv_seq_pkg.sv
// Shared types and encodings for the riscv_seq_ctrl sequencer.
// Build option: RISCV_SEQ_BEQ_EN enables decoding of BEQ (otherwise BEQ traps).
package riscv_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT,
    ST_TRAP
  } state_e;

  typedef enum logic [2:0] {
    K_NONE,
    K_ADDI,
    K_ADD,
    K_SUB,
    K_BNE,
    K_BEQ
  } kind_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

`ifdef RISCV_SEQ_BEQ_EN
  localparam bit BEQ_EN = 1'b1;
`else
  localparam bit BEQ_EN = 1'b0;
`endif

  // ECALL is recognised separately; anything returning K_NONE traps.
  function automatic kind_e decode_kind(input logic [31:0] instr);
    kind_e k;
    k = K_NONE;
    case (instr[6:0])
      OP_IMM: begin
        if (instr[14:12] == F3_ADDSUB) k = K_ADDI;
      end
      OP_REG: begin
        if (instr[14:12] == F3_ADDSUB) begin
          if (instr[31:25] == F7_ADD)      k = K_ADD;
          else if (instr[31:25] == F7_SUB) k = K_SUB;
        end
      end
      OP_BRANCH: begin
        if (instr[14:12] == F3_BNE)                k = K_BNE;
        else if (BEQ_EN && instr[14:12] == F3_BEQ) k = K_BEQ;
      end
      default: k = K_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/riscv_seq_immgen.sv
// Combinational immediate generator: sign-extended I-type and B-type immediates.
module riscv_seq_immgen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  output logic [DATA_WIDTH-1:0] imm_i,
  output logic [DATA_WIDTH-1:0] imm_b
);

  assign imm_i = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};

  // B-type offsets are in halfwords, so bit 0 is always zero.
  assign imm_b = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};

endmodule

// File: rtl/riscv_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the RV32I-subset datapath.
// Build option: RISCV_SEQ_BEQ_EN (see riscv_seq_pkg) enables BEQ.
//
// state  | meaning
// FETCH  | imem_req held with stable imem_addr until imem_ack
// DECODE | register addresses presented, instruction classified
// EXEC   | datapath controls driven for one cycle, pc/retired advance
// HALT   | ECALL reached, absorbing until rst
// TRAP   | unsupported/misaligned instruction, absorbing until rst
module riscv_seq_ctrl
  import riscv_seq_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic [DATA_WIDTH-1:0] ImmOp,
  output logic                  RegWrite,
  output logic                  ALUsrc,
  output logic                  ALUctrl,
  input  logic                  EQ,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] retired,
  output logic                  halted,
  output logic                  illegal
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] retired_q, retired_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  halted_q, halted_d;
  logic                  illegal_q, illegal_d;

  kind_e                 kind;
  logic [DATA_WIDTH-1:0] imm_i, imm_b, target;
  logic                  taken, wr_en;

  riscv_seq_immgen #(.DATA_WIDTH(DATA_WIDTH)) u_immgen (
    .instr (instr_q[31:0]),
    .imm_i (imm_i),
    .imm_b (imm_b)
  );

  assign kind   = decode_kind(instr_q[31:0]);
  assign target = pc_q + imm_b;

  assign rs1       = instr_q[19:15];
  assign rs2       = instr_q[24:20];
  assign rd        = instr_q[11:7];
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    instr_d   = instr_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    RegWrite  = 1'b0;
    ALUsrc    = 1'b0;
    ALUctrl   = ALU_ADD;
    ImmOp     = '0;
    taken     = 1'b0;
    wr_en     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (instr_q[31:0] == INSTR_ECALL) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (kind == K_NONE) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (kind)
          K_ADDI: begin
            ALUsrc = 1'b1;
            ImmOp  = imm_i;
            wr_en  = 1'b1;
          end
          K_ADD: wr_en = 1'b1;
          K_SUB: begin
            ALUctrl = ALU_SUB;
            wr_en   = 1'b1;
          end
          K_BNE: begin
            ALUctrl = ALU_SUB;
            taken   = ~EQ;
          end
          K_BEQ: begin
            ALUctrl = ALU_SUB;
            taken   = EQ;
          end
          default: ;
        endcase

        RegWrite = wr_en && (rd != 5'd0);

        // Only a taken branch can leave the word-aligned address space.
        if (taken && target[1]) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          pc_d      = taken ? target : pc_q + PC_STEP;
          retired_d = retired_q + ONE;
          state_d   = ST_FETCH;
        end
      end

      ST_HALT, ST_TRAP: ;

      default: state_d = ST_FETCH;
    endcase

    // Reset dominates: no fetch request or write pulse while rst is high.
    if (rst) begin
      imem_req = 1'b0;
      RegWrite = 1'b0;
      ALUsrc   = 1'b0;
      ALUctrl  = ALU_ADD;
      ImmOp    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      instr_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      instr_q   <= instr_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// Directed-vector bench for riscv_seq_ctrl with a small imem responder and datapath model.
module tb_riscv_seq_ctrl;

  localparam logic [31:0] ECALL_W = 32'h0000_0073;
  localparam logic [31:0] ADDI_X10_5 = 32'h0050_0513;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ImmOp, pc, retired;
  logic        RegWrite, ALUsrc, ALUctrl, EQ, halted, illegal;

  logic [31:0] mem      [0:15];
  logic [31:0] regs     [0:31];
  logic [31:0] reg_init [0:31];
  logic        dp_init = 1'b1;
  int          ack_delay = 0;
  int          ack_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] op1, op2, alu_out;

  riscv_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .ImmOp(ImmOp), .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
    .EQ(EQ), .pc(pc), .retired(retired), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Datapath model: register file, operand mux, ALU and comparator.
  assign op1     = regs[rs1];
  assign op2     = ALUsrc ? ImmOp : regs[rs2];
  assign EQ      = (op1 == op2);
  assign alu_out = ALUctrl ? (op1 - op2) : (op1 + op2);

  always @(posedge clk) begin
    if (dp_init) begin
      for (int i = 0; i < 32; i++) regs[i] <= reg_init[i];
    end else if (RegWrite && rd != 5'd0) begin
      regs[rd] <= alu_out;
    end
  end

  // Instruction memory: acks after ack_delay waiting cycles of imem_req.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        if (ack_cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr[5:2]];
          ack_cnt    = 0;
        end else begin
          imem_ack = 1'b0;
          ack_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        ack_cnt  = 0;
      end
    end
  end

  task automatic setup_prog();
    for (int i = 0; i < 16; i++) mem[i] = ECALL_W;
    for (int i = 0; i < 32; i++) reg_init[i] = '0;
    ack_delay = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    dp_init = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    dp_init = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (halted === 1'b1 || illegal === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    setup_prog();
    mem[0] = ADDI_X10_5;
    rst = 1'b1;
    dp_init = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({imem_req, RegWrite, ALUsrc, ALUctrl, halted, illegal, rs1, rs2, rd} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got req=%b rw=%b src=%b ctl=%b halt=%b ill=%b rs1=%0d rs2=%0d rd=%0d, expected all 0",
               imem_req, RegWrite, ALUsrc, ALUctrl, halted, illegal, rs1, rs2, rd);
    end
    vectors++;
    if ({pc, retired, ImmOp} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_regs: got pc=%h retired=%0d imm=%h, expected 0/0/0", pc, retired, ImmOp);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    dp_init = 1'b0;
    @(negedge clk);
    vectors++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_first_fetch: got req=%b addr=%h, expected 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_addi();
    setup_prog();
    mem[0] = ADDI_X10_5;
    do_reset();
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL addi_fetch: got req=%b, expected 1", imem_req);
    end
    @(negedge clk);
    vectors++;
    if ({imem_req, RegWrite, rs1} !== {1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL addi_decode: got req=%b rw=%b rs1=%0d, expected 0/0/0", imem_req, RegWrite, rs1);
    end
    @(negedge clk);
    vectors++;
    if ({rd, ImmOp, ALUsrc, ALUctrl, RegWrite} !== {5'd10, 32'd5, 1'b1, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL addi_exec: got rd=%0d imm=%h src=%b ctl=%b rw=%b, expected 10/5/1/0/1",
               rd, ImmOp, ALUsrc, ALUctrl, RegWrite);
    end
    @(negedge clk);
    vectors++;
    if ({pc, retired, regs[10], RegWrite} !== {32'd4, 32'd1, 32'd5, 1'b0}) begin
      miscompares++;
      $display("FAIL addi_retire: got pc=%0d retired=%0d x10=%0d rw=%b, expected 4/1/5/0",
               pc, retired, regs[10], RegWrite);
    end
  endtask

  task automatic test_loop();
    int  taken_cnt;
    bit  reached, ok;
    logic [31:0] prev_pc;
    int  req_cnt;
    setup_prog();
    mem[0] = 32'hFFF0_8093;  // addi x1,x1,-1
    mem[1] = 32'hFE00_9EE3;  // bne  x1,x0,-4
    reg_init[1] = 32'd3;
    do_reset();
    taken_cnt = 0;
    reached = 1'b0;
    prev_pc = 32'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pc === 32'd0 && prev_pc === 32'd4) taken_cnt++;
      prev_pc = pc;
      if (pc === 32'd8) begin
        reached = 1'b1;
        break;
      end
    end
    vectors++;
    if (!reached) begin
      miscompares++;
      $display("FAIL loop_timeout: pc=%h never reached 00000008", pc);
    end
    vectors++;
    if ({retired, regs[1]} !== {32'd6, 32'd0} || taken_cnt != 2) begin
      miscompares++;
      $display("FAIL loop_result: got retired=%0d x1=%0d taken=%0d, expected 6/0/2",
               retired, regs[1], taken_cnt);
    end
    wait_done(20, ok);
    req_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (imem_req === 1'b1) req_cnt++;
    end
    vectors++;
    if (!ok || {halted, illegal, pc, retired} !== {1'b1, 1'b0, 32'd8, 32'd6} || req_cnt != 0) begin
      miscompares++;
      $display("FAIL loop_halt: got halt=%b ill=%b pc=%0d retired=%0d reqs=%0d, expected 1/0/8/6/0",
               halted, illegal, pc, retired, req_cnt);
    end
  endtask

  task automatic test_ack_delay();
    int cycles;
    bit held, held2, seen;
    setup_prog();
    mem[0] = ADDI_X10_5;
    ack_delay = 3;
    do_reset();
    cycles = 0;
    held = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cycles++;
      if (RegWrite === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (cycles <= 4 && (imem_req !== 1'b1 || imem_addr !== 32'd0)) held = 1'b0;
    end
    vectors++;
    if (!seen || cycles != 6 || !held) begin
      miscompares++;
      $display("FAIL ack_delay_first: got seen=%b exec_cycle=%0d held=%b, expected 1/6/1", seen, cycles, held);
    end
    held2 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (imem_req !== 1'b1 || imem_addr !== 32'd4) held2 = 1'b0;
    end
    vectors++;
    if (!held2) begin
      miscompares++;
      $display("FAIL ack_delay_second: got req=%b addr=%h not held, expected 1/00000004 for 4 cycles",
               imem_req, imem_addr);
    end
    ack_delay = 0;
  endtask

  task automatic test_illegal();
    bit ok;
    setup_prog();
    mem[0] = ADDI_X10_5;
    mem[1] = 32'hFFFF_FFFF;
    do_reset();
    wait_done(30, ok);
    vectors++;
    if (!ok || {illegal, halted, imem_req, RegWrite, pc, retired} !== {4'b1000, 32'd4, 32'd1}) begin
      miscompares++;
      $display("FAIL illegal_trap: got ill=%b halt=%b req=%b rw=%b pc=%0d retired=%0d, expected 1/0/0/0/4/1",
               illegal, halted, imem_req, RegWrite, pc, retired);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if ({illegal, imem_req, pc} !== {1'b1, 1'b0, 32'd4}) begin
      miscompares++;
      $display("FAIL illegal_absorb: got ill=%b req=%b pc=%0d, expected 1/0/4", illegal, imem_req, pc);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({illegal, imem_req, pc, retired} !== {1'b0, 1'b1, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL illegal_clear: got ill=%b req=%b pc=%0d retired=%0d, expected 0/1/0/0",
               illegal, imem_req, pc, retired);
    end
  endtask

  task automatic test_add_sub();
    bit   ok, x0_write;
    logic sub_ctl;
    setup_prog();
    mem[0] = 32'h0020_8233;  // add x4,x1,x2
    mem[1] = 32'h4020_81B3;  // sub x3,x1,x2
    mem[2] = 32'h0020_8033;  // add x0,x1,x2
    reg_init[1] = 32'd10;
    reg_init[2] = 32'd3;
    do_reset();
    x0_write = 1'b0;
    sub_ctl = 1'bx;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (RegWrite === 1'b1 && rd === 5'd3) sub_ctl = ALUctrl;
      if (RegWrite === 1'b1 && rd === 5'd0) x0_write = 1'b1;
      if (halted === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if ({regs[4], regs[3], sub_ctl} !== {32'd13, 32'd7, 1'b1}) begin
      miscompares++;
      $display("FAIL add_sub_results: got x4=%0d x3=%0d sub_ctl=%b, expected 13/7/1", regs[4], regs[3], sub_ctl);
    end
    vectors++;
    if (!ok || x0_write || {retired, pc, halted} !== {32'd3, 32'd12, 1'b1}) begin
      miscompares++;
      $display("FAIL add_x0_halt: got x0_write=%b retired=%0d pc=%0d halt=%b, expected 0/3/12/1",
               x0_write, retired, pc, halted);
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    setup_prog();
    mem[0] = 32'h0000_9363;  // bne x1,x0,+6
    reg_init[1] = 32'd3;
    do_reset();
    wait_done(30, ok);
    vectors++;
    if (!ok || {illegal, halted, pc, retired} !== {2'b10, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL misaligned_branch: got ill=%b halt=%b pc=%0d retired=%0d, expected 1/0/0/0",
               illegal, halted, pc, retired);
    end
  endtask

  task automatic test_rst_exec();
    setup_prog();
    mem[0] = ADDI_X10_5;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({RegWrite, ALUsrc, ImmOp, imem_req} !== '0) begin
      miscompares++;
      $display("FAIL rst_exec_pulse: got rw=%b src=%b imm=%h req=%b, expected all 0",
               RegWrite, ALUsrc, ImmOp, imem_req);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({imem_req, pc, retired, regs[10], rd} !== {1'b1, 32'd0, 32'd0, 32'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL rst_exec_after: got req=%b pc=%0d retired=%0d x10=%0d rd=%0d, expected 1/0/0/0/0",
               imem_req, pc, retired, regs[10], rd);
    end
  endtask

  task automatic test_beq();
    bit ok;
    setup_prog();
    mem[0] = 32'h0010_8463;  // beq x1,x1,+8
    mem[1] = 32'hFFFF_FFFF;
    reg_init[1] = 32'd7;
    do_reset();
    wait_done(30, ok);
    vectors++;
`ifdef RISCV_SEQ_BEQ_EN
    if (!ok || {halted, illegal, pc, retired} !== {2'b10, 32'd8, 32'd1}) begin
      miscompares++;
      $display("FAIL beq_taken: got halt=%b ill=%b pc=%0d retired=%0d, expected 1/0/8/1",
               halted, illegal, pc, retired);
    end
`else
    if (!ok || {halted, illegal, pc, retired} !== {2'b01, 32'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL beq_trap: got halt=%b ill=%b pc=%0d retired=%0d, expected 0/1/0/0",
               halted, illegal, pc, retired);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_addi();
    test_loop();
    test_ack_delay();
    test_illegal();
    test_add_sub();
    test_misaligned();
    test_rst_exec();
    test_beq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
